adrv9001_ctrl_seq: RTL and testbench
====================================

// Module: adrv9001_ctrl_seq
// PURPOSE
//  Sequences the ADRV9001 control pins (RSTN, TX1/TX2/RX1/RX2 enables) with programmable timing.
//  Sits directly upstream of the GPIO pin-mapping stage: ctrl_o drives gpio_tri_o[17:13].
//  Also synchronises the ADRV9001 IRQ pin and holds it as a sticky, edge-detected status bit.
//  Software or the TDD logic issues level requests; this block owns every pin transition.
// PARAMETERS
//  SETUP_CYCLES  default 16    clocks from a request rising edge to its enable pin asserting
//  GUARD_CYCLES  default 32    minimum low time of an enable pin after it deasserts
//  RST_CYCLES    default 1024  RSTN low time per reset pulse
//  SETTLE_CYCLES default 4096  wait after RSTN rises, before ready asserts
// PORTS
//  clk        in   1   block clock
//  rst        in   1   synchronous, active-high reset
//  rst_req    in   1   one-cycle pulse: re-run the ADRV9001 reset sequence
//  en_req     in   4   level requests {rx1,rx2,tx1,tx2}
//  irq_in     in   1   ADRV9001 IRQ pin (asynchronous)
//  irq_clr    in   1   one-cycle pulse: clear irq_sticky
//  ctrl_o     out  5   {rx1,rx2,tx1,tx2,rstn}, mapped to gpio_tri_o[17:13]
//  en_state   out  4   1 = the matching enable pin is high
//  ready      out  1   reset sequence complete; enables are permitted
//  irq_sticky out  1   latched IRQ rising edge
// BEHAVIOUR
//  All outputs are registered. Reset values: ctrl_o=5'b00000 (RSTN low), en_state=0, ready=0, irq_sticky=0.
//  Reset FSM: R_ASSERT -> R_SETTLE -> R_DONE.
//   - rst drives R_ASSERT, so the device is always reset at power-up.
//   - R_ASSERT: rstn=0 for RST_CYCLES clocks, then R_SETTLE.
//   - R_SETTLE: rstn=1 for SETTLE_CYCLES clocks, then R_DONE.
//   - R_DONE: ready=1.
//   - rst_req in any state returns to R_ASSERT with the counter cleared and ready=0 on the next clock.
//  While ready=0, all channel FSMs are forced to OFF and their enable pins go low on the same edge.
//  Per-channel FSM (4 instances): OFF, ARM, ON, GUARD.
//   - OFF:   en_req=1 and ready=1 -> ARM, counter=0.
//   - ARM:   pin low. en_req drops -> OFF (no pulse). Counter reaches SETUP_CYCLES-1 -> ON.
//   - ON:    pin high. en_req drops -> GUARD; the pin is low on the next clock.
//   - GUARD: pin low for GUARD_CYCLES clocks, then OFF. If en_req is still high at that point,
//            OFF immediately goes to ARM, so a re-request waits out the guard.
//  Latency from en_req rising edge to pin high is SETUP_CYCLES+1 clocks from OFF.
//  Latency from en_req falling edge to pin low is 1 clock.
//  Counter width is $clog2(max param)+1. Counters saturate and never wrap.
//  A parameter value of 0 is treated as 1.
//  IRQ path: 2-flop synchroniser, then a rising-edge detect that sets irq_sticky.
//   - irq_clr clears irq_sticky.
//   - An edge in the same cycle as irq_clr wins, so irq_sticky stays 1.
// CONFIGURATION
//  `ADRV9001_TRX_INTERLOCK_EN
//   - Defined: on each channel (1 or 2), TX and RX are mutually exclusive. A request leaves OFF
//     only if the opposite direction on that channel is in OFF. If both leave OFF in the same
//     cycle, TX wins.
//   - Undefined: the four channels are fully independent.
// STRUCTURE
//  Package adrv9001_ctrl_pkg:
//   - chan_state_t enum {OFF, ARM, ON, GUARD}
//   - rst_state_t enum {R_ASSERT, R_SETTLE, R_DONE}
//   - index localparams CH_RX1=3, CH_RX2=2, CH_TX1=1, CH_TX2=0
//   - CTRL_RSTN_BIT=0
//  Sub-module adrv9001_en_chan: one channel FSM plus its counter, instantiated 4x.
//   Inputs: en_req, ready, inhibit (interlock). Outputs: pin, state.
// TESTING
//  Use SETUP=4, GUARD=8, RST=16, SETTLE=32.
//  1. Release rst -> rstn=0 for 16 clocks, then 1; ready=1 exactly 32 clocks later.
//  2. ready=1, en_req[tx1] rises at cycle t -> ctrl_o tx1 bit = 1 at t+5; drop at u -> 0 at u+1.
//  3. tx1 drops, then re-requests 2 clocks later -> pin stays low 8 clocks (guard), then 4 setup clocks, then high.
//  4. rst_req while tx1 and rx2 are ON -> both pins low and rstn=0 next clock; ready=0; full reset sequence reruns.
//  5. irq_in rises in the same cycle irq_clr pulses (edge reaching the detector) -> irq_sticky=1; a later irq_clr alone -> 0.
//  6. With `ADRV9001_TRX_INTERLOCK_EN, rx1 ON and tx1 requested -> tx1 stays OFF until rx1 is back in OFF. Same test
//     with the macro undefined -> tx1 pin high SETUP_CYCLES+1 clocks after its request.

Source files
------------

// File: rtl/adrv9001_ctrl_pkg.sv
// Shared types, pin indices and parameter helpers for the ADRV9001 control-pin sequencer.
package adrv9001_ctrl_pkg;

  typedef enum logic [1:0] {OFF, ARM, ON, GUARD} chan_state_t;
  typedef enum logic [1:0] {R_ASSERT, R_SETTLE, R_DONE} rst_state_t;

  localparam int CH_RX1 = 3;
  localparam int CH_RX2 = 2;
  localparam int CH_TX1 = 1;
  localparam int CH_TX2 = 0;

  localparam int CTRL_RSTN_BIT = 0;

  // A zero-length phase would never let the counter match, so zero behaves as one.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adrv9001_en_chan.sv
// One ADRV9001 enable-pin channel: OFF -> ARM (setup delay) -> ON -> GUARD (minimum low time).
module adrv9001_en_chan
  import adrv9001_ctrl_pkg::*;
#(
  parameter int SETUP_CYCLES = 16,
  parameter int GUARD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_req,
  input  logic       ready,
  input  logic       inhibit,
  output logic       pin,
  output logic [1:0] state
);

  localparam int SETUP_N = at_least_one(SETUP_CYCLES);
  localparam int GUARD_N = at_least_one(GUARD_CYCLES);
  localparam int CNT_W   = $clog2(max2(SETUP_N, GUARD_N)) + 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_N - 1);

  chan_state_t      st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign state   = st;

  // Losing ready drops the pin on the very edge it is seen, whatever the channel was doing.
  always_ff @(posedge clk) begin
    if (rst || !ready) begin
      st  <= OFF;
      cnt <= '0;
      pin <= 1'b0;
    end else begin
      case (st)
        OFF: begin
          if (en_req && !inhibit) begin
            st  <= ARM;
            cnt <= '0;
          end
        end
        ARM: begin
          if (!en_req) begin
            st <= OFF;
          end else if (cnt == SETUP_LAST) begin
            st  <= ON;
            pin <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ON: begin
          if (!en_req) begin
            st  <= GUARD;
            cnt <= '0;
            pin <= 1'b0;
          end
        end
        GUARD: begin
          if (cnt == GUARD_LAST) begin
            st <= OFF;
          end else begin
            cnt <= cnt_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/adrv9001_ctrl_seq.sv
// ADRV9001 control-pin sequencer: RSTN pulse/settle, four timed enable pins and a sticky IRQ flag.
// Optional TX/RX mutual exclusion per channel is enabled by defining ADRV9001_TRX_INTERLOCK_EN.
module adrv9001_ctrl_seq
  import adrv9001_ctrl_pkg::*;
#(
  parameter int SETUP_CYCLES  = 16,
  parameter int GUARD_CYCLES  = 32,
  parameter int RST_CYCLES    = 1024,
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_req,
  input  logic [3:0] en_req,
  input  logic       irq_in,
  input  logic       irq_clr,
  output logic [4:0] ctrl_o,
  output logic [3:0] en_state,
  output logic       ready,
  output logic       irq_sticky
);

  localparam int RST_N    = at_least_one(RST_CYCLES);
  localparam int SETTLE_N = at_least_one(SETTLE_CYCLES);
  localparam int RCNT_W   = $clog2(max2(RST_N, SETTLE_N)) + 1;
  localparam logic [RCNT_W-1:0] RST_LAST    = RCNT_W'(RST_N - 1);
  localparam logic [RCNT_W-1:0] SETTLE_LAST = RCNT_W'(SETTLE_N - 1);

  rst_state_t        rst_st;
  logic [RCNT_W-1:0] rcnt;
  logic [RCNT_W-1:0] rcnt_inc;
  logic              rstn;

  assign rcnt_inc = (&rcnt) ? rcnt : rcnt + RCNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || rst_req) begin
      rst_st <= R_ASSERT;
      rcnt   <= '0;
      rstn   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      case (rst_st)
        R_ASSERT: begin
          if (rcnt == RST_LAST) begin
            rst_st <= R_SETTLE;
            rcnt   <= '0;
            rstn   <= 1'b1;
          end else begin
            rcnt <= rcnt_inc;
          end
        end
        R_SETTLE: begin
          if (rcnt == SETTLE_LAST) begin
            rst_st <= R_DONE;
            ready  <= 1'b1;
          end else begin
            rcnt <= rcnt_inc;
          end
        end
        R_DONE: begin
          ready <= 1'b1;
        end
        default: begin
          rst_st <= R_ASSERT;
          rcnt   <= '0;
          rstn   <= 1'b0;
          ready  <= 1'b0;
        end
      endcase
    end
  end

  // Masking with rst_req lets the enable pins fall on the same edge that RSTN falls.
  logic       chan_ready;
  logic [3:0] pins;
  logic [3:0] inhibit;
  logic [1:0] chan_state [4];

  assign chan_ready = ready && !rst_req;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    adrv9001_en_chan #(
      .SETUP_CYCLES(SETUP_CYCLES),
      .GUARD_CYCLES(GUARD_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en_req (en_req[i]),
      .ready  (chan_ready),
      .inhibit(inhibit[i]),
      .pin    (pins[i]),
      .state  (chan_state[i])
    );
    assign en_state[i] = (chan_state[i] == ON);
  end

`ifdef ADRV9001_TRX_INTERLOCK_EN
  // TX only looks at RX state; RX also yields to a same-cycle TX request so TX wins ties.
  assign inhibit[CH_TX1] = (chan_state[CH_RX1] != OFF);
  assign inhibit[CH_TX2] = (chan_state[CH_RX2] != OFF);
  assign inhibit[CH_RX1] = (chan_state[CH_TX1] != OFF) || en_req[CH_TX1];
  assign inhibit[CH_RX2] = (chan_state[CH_TX2] != OFF) || en_req[CH_TX2];
`else
  assign inhibit = '0;
`endif

  assign ctrl_o[CTRL_RSTN_BIT] = rstn;
  assign ctrl_o[4:1]           = {pins[CH_RX1], pins[CH_RX2], pins[CH_TX1], pins[CH_TX2]};

  logic irq_s1;
  logic irq_s2;
  logic irq_s3;

  // A fresh edge beats a simultaneous clear so no IRQ is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s1     <= 1'b0;
      irq_s2     <= 1'b0;
      irq_s3     <= 1'b0;
      irq_sticky <= 1'b0;
    end else begin
      irq_s1 <= irq_in;
      irq_s2 <= irq_s1;
      irq_s3 <= irq_s2;
      if (irq_s2 && !irq_s3) begin
        irq_sticky <= 1'b1;
      end else if (irq_clr) begin
        irq_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adrv9001_ctrl_seq.sv
// Self-checking bench for adrv9001_ctrl_seq: fixed vector table, random traffic against a
// timing model, and the TX/RX interlock corner (either build of ADRV9001_TRX_INTERLOCK_EN).
module tb_adrv9001_ctrl_seq;

  localparam int SETUP  = 4;
  localparam int GUARD  = 8;
  localparam int RSTC   = 16;
  localparam int SETTLE = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_req;
  logic [3:0] en_req;
  logic       irq_in;
  logic       irq_clr;
  logic [4:0] ctrl_o;
  logic [3:0] en_state;
  logic       ready;
  logic       irq_sticky;

  always #5 clk = ~clk;

  adrv9001_ctrl_seq #(
    .SETUP_CYCLES (SETUP),
    .GUARD_CYCLES (GUARD),
    .RST_CYCLES   (RSTC),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rst_req   (rst_req),
    .en_req    (en_req),
    .irq_in    (irq_in),
    .irq_clr   (irq_clr),
    .ctrl_o    (ctrl_o),
    .en_state  (en_state),
    .ready     (ready),
    .irq_sticky(irq_sticky)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       rst;
    logic       rst_req;
    logic [3:0] en;
    logic       irq;
    logic       clr;
    int         cycles;
    logic [4:0] ctrl;
    logic [3:0] en_st;
    logic       rdy;
    logic       stk;
  } vec_t;

  vec_t tbl[$];

  // Timing model: edges since the last reset, per-channel countdowns, IRQ sample history.
  int m_n = 0;
  bit m_on[4];
  int m_wait[4];
  int m_cool[4];
  bit m_sticky = 1'b0;
  bit m_hist[4];

  function automatic logic [10:0] expected();
    logic rstn_e;
    logic rdy_e;
    rstn_e = (m_n >= RSTC);
    rdy_e  = (m_n >= RSTC + SETTLE);
    return {m_on[3], m_on[2], m_on[1], m_on[0], rstn_e,
            m_on[3], m_on[2], m_on[1], m_on[0], rdy_e, m_sticky};
  endfunction

  task automatic modelStep();
    bit ready_prev;
    bit busy[4];
    bit blk;
    bit edge_seen;
    ready_prev = (m_n >= RSTC + SETTLE);
    for (int i = 0; i < 4; i++) busy[i] = m_on[i] || (m_wait[i] >= 0) || (m_cool[i] > 0);
    if (rst || rst_req) m_n = 0;
    else if (m_n < 1000000) m_n++;
    for (int i = 0; i < 4; i++) begin
      blk = 1'b0;
`ifdef ADRV9001_TRX_INTERLOCK_EN
      case (i)
        1: blk = busy[3];
        0: blk = busy[2];
        3: blk = busy[1] || en_req[1];
        default: blk = busy[0] || en_req[0];
      endcase
`endif
      if (rst || rst_req || !ready_prev) begin
        m_on[i] = 1'b0; m_wait[i] = -1; m_cool[i] = 0;
      end else if (m_on[i]) begin
        if (!en_req[i]) begin m_on[i] = 1'b0; m_cool[i] = GUARD; end
      end else if (m_cool[i] > 0) begin
        m_cool[i]--;
      end else if (m_wait[i] >= 0) begin
        if (!en_req[i]) m_wait[i] = -1;
        else begin
          m_wait[i]++;
          if (m_wait[i] == SETUP) begin m_on[i] = 1'b1; m_wait[i] = -1; end
        end
      end else if (en_req[i] && !blk) begin
        m_wait[i] = 0;
      end
    end
    if (rst) begin
      for (int k = 0; k < 4; k++) m_hist[k] = 1'b0;
      m_sticky = 1'b0;
    end else begin
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq_in;
      edge_seen = m_hist[2] && !m_hist[3];
      if (edge_seen) m_sticky = 1'b1;
      else if (irq_clr) m_sticky = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [10:0] actual, input logic [10:0] exp_v);
    vectors++;
    if (actual !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b ({ctrl_o,en_state,ready,irq_sticky})",
               name, actual, exp_v);
    end
  endtask

  function automatic logic [10:0] observed();
    return {ctrl_o, en_state, ready, irq_sticky};
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("model", observed(), expected());
  endtask

  task automatic addRow(input logic r, input logic rq, input logic [3:0] e, input logic iq,
                        input logic cl, input int cyc, input logic [4:0] c, input logic [3:0] es,
                        input logic rd, input logic sk);
    vec_t v;
    v.rst = r; v.rst_req = rq; v.en = e; v.irq = iq; v.clr = cl; v.cycles = cyc;
    v.ctrl = c; v.en_st = es; v.rdy = rd; v.stk = sk;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    rst = v.rst; rst_req = v.rst_req; en_req = v.en; irq_in = v.irq; irq_clr = v.clr;
    repeat (v.cycles) tick();
    checkOutput(name, observed(), {v.ctrl, v.en_st, v.rdy, v.stk});
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin m_on[i] = 1'b0; m_wait[i] = -1; m_cool[i] = 0; m_hist[i] = 1'b0; end
    rst = 1'b1; rst_req = 1'b0; en_req = 4'b0; irq_in = 1'b0; irq_clr = 1'b0;

    //     rst rq  en      irq clr cyc  ctrl      en_st   rdy  stk
    addRow(1, 0, 4'b0000, 0, 0,  3, 5'b00000, 4'b0000, 0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 15, 5'b00000, 4'b0000, 0, 0);
    addRow(0, 0, 4'b0000, 0, 0,  1, 5'b00001, 4'b0000, 0, 0);
    addRow(0, 0, 4'b0000, 0, 0, 31, 5'b00001, 4'b0000, 0, 0);
    addRow(0, 0, 4'b0000, 0, 0,  1, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0010, 0, 0,  4, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0010, 0, 0,  1, 5'b00101, 4'b0010, 1, 0);
    addRow(0, 0, 4'b0000, 0, 0,  1, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0000, 0, 0,  1, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0010, 0, 0, 11, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0010, 0, 0,  1, 5'b00101, 4'b0010, 1, 0);
    addRow(0, 0, 4'b0110, 0, 0,  5, 5'b01101, 4'b0110, 1, 0);
    addRow(0, 1, 4'b0110, 0, 0,  1, 5'b00000, 4'b0000, 0, 0);
    addRow(0, 0, 4'b0110, 0, 0, 15, 5'b00000, 4'b0000, 0, 0);
    addRow(0, 0, 4'b0110, 0, 0,  1, 5'b00001, 4'b0000, 0, 0);
    addRow(0, 0, 4'b0110, 0, 0, 32, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0110, 0, 0,  5, 5'b01101, 4'b0110, 1, 0);
    addRow(0, 0, 4'b0000, 0, 0, 10, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0000, 1, 0,  2, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0000, 1, 1,  1, 5'b00001, 4'b0000, 1, 1);
    addRow(0, 0, 4'b0000, 1, 0,  3, 5'b00001, 4'b0000, 1, 1);
    addRow(0, 0, 4'b0000, 1, 1,  1, 5'b00001, 4'b0000, 1, 0);
    addRow(0, 0, 4'b0000, 0, 0,  3, 5'b00001, 4'b0000, 1, 0);

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], $sformatf("row%0d", i));

    // Random traffic with occasional resets, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(1499) == 0);
      rst_req = ($urandom_range(399) == 0);
      if ($urandom_range(7) == 0) en_req = en_req ^ (4'b0001 << $urandom_range(3));
      if ($urandom_range(9) == 0) irq_in = ~irq_in;
      irq_clr = ($urandom_range(14) == 0);
      tick();
    end

    // Interlock corner: rx1 is ON when tx1 is requested.
    rst = 1'b1; rst_req = 1'b0; en_req = 4'b0; irq_in = 1'b0; irq_clr = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 200 && !ready; k++) tick();
    checkOutput("ready_wait", {10'b0, ready}, 11'b1);
    en_req = 4'b1000;
    repeat (SETUP + 1) tick();
    checkOutput("rx1_on", {ctrl_o, en_state}, {5'b10001, 4'b1000});
    en_req = 4'b1010;
    repeat (SETUP + 1) tick();
`ifdef ADRV9001_TRX_INTERLOCK_EN
    checkOutput("tx1_blocked", {ctrl_o, en_state}, {5'b10001, 4'b1000});
    en_req = 4'b0010;
    repeat (13) tick();
    checkOutput("tx1_wait_guard", {ctrl_o, en_state}, {5'b00001, 4'b0000});
    tick();
    checkOutput("tx1_after_rx1", {ctrl_o, en_state}, {5'b00101, 4'b0010});
`else
    checkOutput("tx1_independent", {ctrl_o, en_state}, {5'b10101, 4'b1010});
`endif
    en_req = 4'b0000;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
